branch_resolve_queue: RTL and testbench

In-order tracking queue that sits between fetch and the bimodal predictor's update port. Fetch allocates one entry per predicted conditional branch, holding its PC and the direction the predictor returned. Execute resolves branches oldest-first. The queue then drives the predictor's write port (write enable, outcome, write PC) one cycle later and raises a mispredict pulse that flushes all younger, wrong-path entries.

---
 rtl/branch_resolve_queue.sv | 105 ++++++++++
 tb/tb_branch_resolve_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order branch tracking queue between fetch and the bimodal predictor's update port.
// Resolves oldest-first, emits a registered predictor write and a mispredict flush pulse.
module branch_resolve_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  input  logic [PC_WIDTH-1:0]          alloc_pc,
  input  logic                         alloc_prediction,
  output logic                         alloc_ready,
  input  logic                         resolve_valid,
  input  logic                         resolve_taken,
  output logic                         update_write_enabled,
  output logic                         update_outcome,
  output logic [PC_WIDTH-1:0]          update_pc,
  output logic                         mispredict,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         resolve_error
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic                pred_mem [DEPTH];

  logic [PtrW-1:0]     head_q, head_d;
  logic [PtrW-1:0]     tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                upd_we_q, upd_outcome_q, mispredict_q, resolve_error_q;
  logic [PC_WIDTH-1:0] upd_pc_q;

  logic resolve_acc, alloc_acc, flush_now;

  assign alloc_ready = (count_q < CntW'(DEPTH));
  assign empty       = (count_q == '0);

  assign resolve_acc = resolve_valid && !empty;
  assign flush_now   = resolve_acc && (resolve_taken != pred_mem[head_q]);
  // A flushing resolve makes any same-cycle alloc wrong-path.
  assign alloc_acc   = alloc_valid && alloc_ready && !flush_now;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (resolve_acc) begin
      head_d = head_q + PtrW'(1);
    end
    if (flush_now) begin
      tail_d  = head_q + PtrW'(1);
      count_d = '0;
    end else begin
      if (alloc_acc) begin
        tail_d = tail_q + PtrW'(1);
      end
      count_d = count_q + CntW'(alloc_acc) - CntW'(resolve_acc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      upd_we_q        <= 1'b0;
      upd_outcome_q   <= 1'b0;
      upd_pc_q        <= '0;
      mispredict_q    <= 1'b0;
      resolve_error_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      upd_we_q     <= resolve_acc;
      mispredict_q <= flush_now;
      if (resolve_acc) begin
        upd_outcome_q <= resolve_taken;
        upd_pc_q      <= pc_mem[head_q];
      end
      if (resolve_valid && empty) begin
        resolve_error_q <= 1'b1;
      end
    end
  end

  // Entry contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (alloc_acc) begin
      pc_mem[tail_q]   <= alloc_pc;
      pred_mem[tail_q] <= alloc_prediction;
    end
  end

  assign update_write_enabled = upd_we_q;
  assign update_outcome       = upd_outcome_q;
  assign update_pc            = upd_pc_q;
  assign mispredict           = mispredict_q;
  assign count                = count_q;
  assign resolve_error        = resolve_error_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a reference queue model predicts every
// accepted resolve; expected updates are queued at drive time and popped on each pulse.
module tb_branch_resolve_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PC_WIDTH = 16;
  localparam int unsigned CntW     = $clog2(DEPTH + 1);

  typedef struct {
    logic [PC_WIDTH-1:0] pc;
    logic                pred;
  } ent_t;

  typedef struct {
    logic [PC_WIDTH-1:0] pc;
    logic                outcome;
    logic                mis;
  } upd_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                alloc_valid = 1'b0;
  logic [PC_WIDTH-1:0] alloc_pc = '0;
  logic                alloc_prediction = 1'b0;
  logic                alloc_ready;
  logic                resolve_valid = 1'b0;
  logic                resolve_taken = 1'b0;
  logic                update_write_enabled;
  logic                update_outcome;
  logic [PC_WIDTH-1:0] update_pc;
  logic                mispredict;
  logic [CntW-1:0]     count;
  logic                empty;
  logic                resolve_error;

  branch_resolve_queue #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .alloc_valid          (alloc_valid),
    .alloc_pc             (alloc_pc),
    .alloc_prediction     (alloc_prediction),
    .alloc_ready          (alloc_ready),
    .resolve_valid        (resolve_valid),
    .resolve_taken        (resolve_taken),
    .update_write_enabled (update_write_enabled),
    .update_outcome       (update_outcome),
    .update_pc            (update_pc),
    .mispredict           (mispredict),
    .count                (count),
    .empty                (empty),
    .resolve_error        (resolve_error)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t mq[$];
  upd_t exp_q[$];
  logic m_err = 1'b0;
  logic m_pulse = 1'b0;
  logic m_mis = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    check({tag, ".alloc_ready"}, 32'(alloc_ready), 32'(mq.size() < DEPTH));
    check({tag, ".resolve_error"}, 32'(resolve_error), 32'(m_err));
  endtask

  // One clock: model decides acceptance from pre-edge state, then outputs are compared.
  task automatic step(input logic av, input logic [PC_WIDTH-1:0] apc, input logic apred,
                      input logic rv, input logic rt, input string tag);
    bit   ready, racc, aacc, mis;
    ent_t e;
    upd_t u;
    alloc_valid      = av;
    alloc_pc         = apc;
    alloc_prediction = apred;
    resolve_valid    = rv;
    resolve_taken    = rt;
    ready = (mq.size() < DEPTH);
    racc  = rv && (mq.size() > 0);
    if (rv && mq.size() == 0) m_err = 1'b1;
    mis   = racc && (rt != mq[0].pred);
    aacc  = av && ready && !mis;
    if (racc) begin
      e = mq.pop_front();
      u.pc = e.pc;
      u.outcome = rt;
      u.mis = mis;
      exp_q.push_back(u);
    end
    if (mis) mq.delete();
    if (aacc) begin
      e.pc = apc;
      e.pred = apred;
      mq.push_back(e);
    end
    m_pulse = racc;
    m_mis   = mis;
    @(posedge clk);
    #1;
    alloc_valid   = 1'b0;
    resolve_valid = 1'b0;
    check({tag, ".upd_we"}, 32'(update_write_enabled), 32'(m_pulse));
    check({tag, ".mispredict"}, 32'(mispredict), 32'(m_mis));
    if (update_write_enabled && exp_q.size() > 0) begin
      u = exp_q.pop_front();
      check({tag, ".upd_pc"}, 32'(update_pc), 32'(u.pc));
      check({tag, ".upd_outcome"}, 32'(update_outcome), 32'(u.outcome));
      check({tag, ".upd_mis"}, 32'(mispredict), 32'(u.mis));
    end
    check_state(tag);
  endtask

  task automatic alloc(input logic [PC_WIDTH-1:0] pc, input logic pred, input string tag);
    step(1'b1, pc, pred, 1'b0, 1'b0, tag);
  endtask

  task automatic resolve(input logic taken, input string tag);
    step(1'b0, '0, 1'b0, 1'b1, taken, tag);
  endtask

  // Resolves the head with its stored prediction (no flush).
  task automatic resolve_ok(input string tag);
    logic t;
    t = (mq.size() > 0) ? mq[0].pred : 1'b0;
    resolve(t, tag);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_err = 1'b0;
  endtask

  initial begin
    logic t;
    // Reset / idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst.upd_we", 32'(update_write_enabled), 32'd0);
    check("rst.upd_outcome", 32'(update_outcome), 32'd0);
    check("rst.upd_pc", 32'(update_pc), 32'd0);
    check("rst.mispredict", 32'(mispredict), 32'd0);
    check_state("rst");

    // In-order update
    alloc(16'h0104, 1'b1, "ino.a0");
    alloc(16'h0208, 1'b0, "ino.a1");
    resolve(1'b1, "ino.r0");
    resolve(1'b0, "ino.r1");

    // Full and wrap
    for (int i = 0; i < 4; i++) alloc(16'h0010 + 16'(i), 1'(i & 1), "full.a");
    alloc(16'h0099, 1'b1, "full.rej");
    resolve_ok("wrap.r0");
    resolve_ok("wrap.r1");
    alloc(16'h0020, 1'b1, "wrap.a0");
    alloc(16'h0021, 1'b0, "wrap.a1");
    for (int i = 0; i < 4; i++) resolve_ok("wrap.drain");

    // Simultaneous alloc/resolve at full, then at count 1
    for (int i = 0; i < 4; i++) alloc(16'h0030 + 16'(i), 1'b1, "sim.a");
    step(1'b1, 16'h00aa, 1'b0, 1'b1, 1'b1, "sim.full");
    resolve_ok("sim.r0");
    resolve_ok("sim.r1");
    step(1'b1, 16'h00bb, 1'b0, 1'b1, 1'b1, "sim.one");
    resolve_ok("sim.drain");

    // Mispredict flush with same-cycle alloc
    alloc(16'h0300, 1'b1, "flush.a0");
    alloc(16'h0304, 1'b0, "flush.a1");
    alloc(16'h0308, 1'b1, "flush.a2");
    step(1'b1, 16'h0777, 1'b1, 1'b1, 1'b0, "flush.r");
    alloc(16'h0400, 1'b0, "flush.after");
    resolve(1'b0, "flush.after_r");

    // Alloc and resolve in the same cycle while empty: no bypass, error set
    step(1'b1, 16'h0500, 1'b1, 1'b1, 1'b1, "nobyp");
    resolve_ok("nobyp.r");

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      if (mq.size() > 0 && $urandom_range(3) != 0) t = mq[0].pred;
      else t = 1'($urandom_range(1));
      step(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)),
           1'($urandom_range(2) == 0), t, "rand");
    end
    while (mq.size() > 0) resolve_ok("rand.drain");

    // Empty resolve, then async reset during an update pulse
    resolve(1'b1, "err.empty");
    check("err.sticky", 32'(resolve_error), 32'd1);
    alloc(16'h0600, 1'b1, "err.a0");
    alloc(16'h0604, 1'b1, "err.a1");
    resolve(1'b1, "err.pulse");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst.upd_we", 32'(update_write_enabled), 32'd0);
    check("arst.mispredict", 32'(mispredict), 32'd0);
    check("arst.upd_pc", 32'(update_pc), 32'd0);
    check_state("arst");
    @(posedge clk);
    #1 reset = 1'b0;
    alloc(16'h0700, 1'b0, "post.a");
    resolve(1'b0, "post.r");
    check("sb.drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
